// File: rtl/psc_seq_pkg.sv
// Shared types and constants for the PSC array sequencer.
package psc_seq_pkg;

    localparam int unsigned CountWidth = 8;
    localparam logic [1:0]  PSC_MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StDone
    } seq_state_e;

endpackage

// File: rtl/psc_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and wraps.
module psc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       valid
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [IdW-1:0] idx;

    always_comb begin
        grant = last_grant;
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest candidate inward so the nearest one after last_grant wins.
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = IdW'((32'(last_grant) + k) % NUM_REQ);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psc_array_sequencer.sv
// Arbitrates NUM_REQ requesters onto one PSC block array and sequences repeated conversions.
// Optional WAIT watchdog compiled in with macro PSC_SEQ_TIMEOUT_EN.
module psc_array_sequencer
    import psc_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [2*NUM_REQ-1:0]           req_mode,
    input  logic [CountWidth*NUM_REQ-1:0]  req_count,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             done,
    output logic [1:0]                     psc_mode,
    output logic                           psc_start,
    input  logic                           psc_finish,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           timeout_err
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    seq_state_e            state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [1:0]            mode_q, mode_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;

    logic [IdW-1:0]        arb_grant;
    logic                  arb_valid;

    logic [1:0]            mode_arr  [NUM_REQ];
    logic [CountWidth-1:0] count_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign mode_arr[i]  = req_mode[2*i +: 2];
        assign count_arr[i] = req_count[CountWidth*i +: CountWidth];
    end

    psc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

`ifdef PSC_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        grant_d     = grant_q;
        mode_d      = mode_q;
        req_ready_d = '0;
        done_d      = '0;
        start_d     = 1'b0;
`ifdef PSC_SEQ_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d                = StStart;
                    grant_d                = arb_grant;
                    mode_d                 = mode_arr[arb_grant];
                    count_d                = (count_arr[arb_grant] == '0) ?
                                             CountWidth'(1) : count_arr[arb_grant];
                    req_ready_d[arb_grant] = 1'b1;
                    // Reserved mode is accepted but never reaches the array.
                    start_d                = (mode_arr[arb_grant] != PSC_MODE_RSVD);
`ifdef PSC_SEQ_TIMEOUT_EN
                    timeout_d              = 1'b0;
`endif
                end
            end
            StStart: begin
                if (mode_q == PSC_MODE_RSVD) begin
                    state_d          = StDone;
                    done_d[grant_q]  = 1'b1;
                end else begin
                    state_d          = StWait;
                end
`ifdef PSC_SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StWait: begin
                if (psc_finish) begin
                    count_d = count_q - CountWidth'(1);
                    if (count_q == CountWidth'(1)) begin
                        state_d         = StDone;
                        done_d[grant_q] = 1'b1;
                    end else begin
                        state_d = StStart;
                        start_d = 1'b1;
                    end
                end
`ifdef PSC_SEQ_TIMEOUT_EN
                else if ({1'b0, wait_cnt_q} + 9'd1 >= 9'(TIMEOUT_CYCLES)) begin
                    state_d         = StDone;
                    done_d[grant_q] = 1'b1;
                    count_d         = '0;
                    timeout_d       = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            grant_q     <= IdW'(NUM_REQ - 1);
            mode_q      <= '0;
            req_ready_q <= '0;
            done_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            grant_q     <= grant_d;
            mode_q      <= mode_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

`ifdef PSC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout_err        = 1'b0;
`endif

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign psc_start = start_q;
    assign psc_mode  = mode_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_psc_array_sequencer.sv
// Self-checking bench for psc_array_sequencer: vector table, corner sequences, random vs model.
module tb_psc_array_sequencer;

    localparam int N  = 2;
    localparam int TO = 10;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [2*N-1:0]         req_mode;
    logic [8*N-1:0]         req_count;
    logic [N-1:0]           req_ready;
    logic [N-1:0]           done;
    logic [1:0]             psc_mode;
    logic                   psc_start;
    logic                   psc_finish;
    logic                   busy;
    logic [$clog2(N)-1:0]   grant_id;
    logic                   timeout_err;

    psc_array_sequencer #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_count   (req_count),
        .req_ready   (req_ready),
        .done        (done),
        .psc_mode    (psc_mode),
        .psc_start   (psc_start),
        .psc_finish  (psc_finish),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {req_ready, done, psc_start, busy, psc_mode, grant_id, timeout_err}
    function automatic logic [9:0] outs();
        return {req_ready, done, psc_start, busy, psc_mode, grant_id, timeout_err};
    endfunction

    typedef struct packed {
        logic [1:0]  valid;
        logic [3:0]  mode;
        logic [15:0] count;
        logic        finish;
        logic [1:0]  e_ready;
        logic [1:0]  e_done;
        logic        e_start;
        logic        e_busy;
        logic [1:0]  e_mode;
        logic        e_grant;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic [1:0] v, input logic [3:0] m, input logic [15:0] c,
                                input logic f, input logic [1:0] r, input logic [1:0] d,
                                input logic s, input logic b, input logic [1:0] em,
                                input logic g);
        vec_t t;
        t.valid = v; t.mode = m; t.count = c; t.finish = f;
        t.e_ready = r; t.e_done = d; t.e_start = s; t.e_busy = b; t.e_mode = em; t.e_grant = g;
        return t;
    endfunction

    // Reference model: transaction-level view of one owner issuing its conversions.
    bit         m_own, m_rsvd, m_in_wait;
    int         m_last, m_left, m_wcyc;
    logic [1:0] m_mode;
    logic [1:0] e_ready, e_done;
    logic       e_start, e_busy, e_terr;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return last;
    endfunction

    function automatic logic [9:0] expected();
        return {e_ready, e_done, e_start, e_busy, m_mode, 1'(m_last), e_terr};
    endfunction

    task automatic model_reset();
        m_own = 0; m_rsvd = 0; m_in_wait = 0; m_last = N - 1; m_left = 0; m_wcyc = 0;
        m_mode = 2'b00; e_ready = '0; e_done = '0; e_start = 0; e_busy = 0; e_terr = 0;
    endtask

    task automatic model_step(input logic [N-1:0] v, input logic [2*N-1:0] m,
                              input logic [8*N-1:0] c, input logic f);
        logic [1:0] nr, nd;
        logic       ns, tmo;
        int         p, cnt;
        nr = '0; nd = '0; ns = 0; tmo = 0;
        if (!m_own) begin
            if (e_done == '0 && v != '0) begin
                p = rr_pick(m_last, v);
                m_last = p; m_own = 1; nr[p] = 1'b1;
                m_mode = m[2*p +: 2];
                cnt = int'(c[8*p +: 8]);
                if (cnt == 0) cnt = 1;
                if (m_mode == 2'b11) m_rsvd = 1;
                else begin ns = 1; m_left = cnt - 1; end
            end
        end else if (m_rsvd) begin
            m_rsvd = 0; m_own = 0; nd[m_last] = 1'b1;
        end else if (m_in_wait) begin
            if (f) begin
                m_in_wait = 0;
                if (m_left == 0) begin m_own = 0; nd[m_last] = 1'b1; end
                else begin m_left--; ns = 1; end
            end
`ifdef PSC_SEQ_TIMEOUT_EN
            else begin
                m_wcyc++;
                if (m_wcyc >= TO) begin
                    m_in_wait = 0; m_own = 0; nd[m_last] = 1'b1; tmo = 1;
                end
            end
`endif
        end
        if (e_start) begin m_in_wait = 1; m_wcyc = 0; end
        if (nr != '0) e_terr = 0;
        else if (tmo) e_terr = 1;
        e_ready = nr; e_done = nd; e_start = ns;
        e_busy  = m_own || (nd != '0);
    endtask

    int got, exp_id, waits, starts, dpulse, spulse;

    initial begin
        #1000000;
        $display("FAIL watchdog: still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_mode = '0; req_count = '0; psc_finish = 1'b0;

        //            valid  mode     count     fin  ready  done   st  bsy mode   gnt
        vecs[0]  = mk(2'b01, 4'b0001, 16'h0001, 0, 2'b01, 2'b00, 1, 1, 2'b01, 0);
        vecs[1]  = mk(2'b00, 4'b0001, 16'h0001, 0, 2'b00, 2'b00, 0, 1, 2'b01, 0);
        vecs[2]  = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 1, 2'b01, 0);
        vecs[3]  = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 1, 2'b01, 0);
        vecs[4]  = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 1, 2'b01, 0);
        vecs[5]  = mk(2'b00, 4'b0000, 16'h0000, 1, 2'b00, 2'b01, 0, 1, 2'b01, 0);
        vecs[6]  = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 2'b01, 0);
        vecs[7]  = mk(2'b10, 4'b1000, 16'h0300, 1, 2'b10, 2'b00, 1, 1, 2'b10, 1);
        vecs[8]  = mk(2'b00, 4'b0000, 16'h0000, 1, 2'b00, 2'b00, 0, 1, 2'b10, 1);
        vecs[9]  = mk(2'b00, 4'b0000, 16'h0000, 1, 2'b00, 2'b00, 1, 1, 2'b10, 1);
        vecs[10] = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 1, 2'b10, 1);
        vecs[11] = mk(2'b00, 4'b0000, 16'h0000, 1, 2'b00, 2'b00, 1, 1, 2'b10, 1);
        vecs[12] = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 1, 2'b10, 1);
        vecs[13] = mk(2'b00, 4'b0000, 16'h0000, 1, 2'b00, 2'b10, 0, 1, 2'b10, 1);
        vecs[14] = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 2'b10, 1);
        vecs[15] = mk(2'b01, 4'b0011, 16'h0004, 0, 2'b01, 2'b00, 0, 1, 2'b11, 0);
        vecs[16] = mk(2'b00, 4'b0000, 16'h0000, 1, 2'b00, 2'b01, 0, 1, 2'b11, 0);
        vecs[17] = mk(2'b00, 4'b0000, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 2'b11, 0);

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_psc_start", 32'(psc_start), 32'd0);
        check("rst_psc_mode", 32'(psc_mode), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'(N - 1));
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 18; k++) begin
            req_valid  = vecs[k].valid;
            req_mode   = vecs[k].mode;
            req_count  = vecs[k].count;
            psc_finish = vecs[k].finish;
            @(negedge clk);
            check($sformatf("vec%0d", k), 32'(outs()),
                  32'({vecs[k].e_ready, vecs[k].e_done, vecs[k].e_start, vecs[k].e_busy,
                       vecs[k].e_mode, vecs[k].e_grant, 1'b0}));
        end

        // Both requesters continuously valid: grants must alternate, starting after owner 0.
        req_valid = 2'b11; req_mode = 4'b0101; req_count = 16'h0101; psc_finish = 1'b1;
        got = 0; exp_id = 1;
        for (int k = 0; k < 40 && got < 6; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("rr_alternate", 32'(req_ready), (exp_id == 1) ? 32'd2 : 32'd1);
                exp_id ^= 1;
                got++;
            end
        end
        check("rr_grant_count", 32'(got), 32'd6);
        req_valid = '0;
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        check("rr_drain_idle", 32'(busy), 32'd0);
        psc_finish = 1'b0;

        // Requester 1, count 2, array never finishes.
        req_valid = 2'b10; req_mode = 4'b1000; req_count = 16'h0200;
        @(negedge clk);
        check("wait_grant", 32'({req_ready, psc_start}), 32'b101);
        req_valid = '0;
`ifdef PSC_SEQ_TIMEOUT_EN
        waits = 0; starts = 0; got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (psc_start) starts++;
            if (done != '0) begin
                got = 1;
                check("to_done_id", 32'(done), 32'd2);
                check("to_err_set", 32'(timeout_err), 32'd1);
            end else waits++;
        end
        check("to_wait_cycles", 32'(waits), 32'(TO));
        check("to_no_restart", 32'(starts), 32'd0);
        req_valid = 2'b01; req_mode = 4'b0001; req_count = 16'h0001;
        @(negedge clk);
        check("to_err_sticky", 32'({timeout_err, busy, psc_start}), 32'b100);
        @(negedge clk);
        check("to_err_clear", 32'({req_ready, timeout_err}), 32'b010);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
`else
        dpulse = 0;
        repeat (30) begin
            @(negedge clk);
            if (done != '0) dpulse++;
        end
        check("nowait_no_done", 32'(dpulse), 32'd0);
        check("nowait_busy", 32'(busy), 32'd1);
        check("nowait_no_err", 32'(timeout_err), 32'd0);
`endif

        // Asynchronous reset in WAIT: everything returns at once, no done, no start.
        #2 reset = 1'b1;
        #1 check("arst_outputs", 32'(outs()), 32'b00_00_0_0_00_1_0);
        dpulse = 0; spulse = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) dpulse++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done != '0) dpulse++;
            if (psc_start) spulse++;
        end
        check("abort_no_done", 32'(dpulse), 32'd0);
        check("abort_no_start", 32'({spulse[7:0], busy}), 32'd0);
        req_valid = 2'b11; req_mode = 4'b0101; req_count = 16'h0101;
        @(negedge clk);
        check("first_grant_req0", 32'(req_ready), 32'd1);
        req_valid = '0; psc_finish = 1'b1;
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        psc_finish = 1'b0;

        // Random traffic against the reference model.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_mode   = 4'($urandom_range(0, 15));
            req_count  = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
            psc_finish = 1'($urandom_range(0, 1));
            model_step(req_valid, req_mode, req_count, psc_finish);
            @(negedge clk);
            check($sformatf("rand_cyc%0d", cyc), 32'(outs()), 32'(expected()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
